// File: rtl/reg_manager.sv
// ----------------------------------------------------------------------------
// reg_manager
//   Register file with a per-register busy scoreboard for in-order issue.
//   It holds 32 x xlen registers. x0 always reads zero, is never busy and
//   ignores writes.
//
//   An issue is accepted when dec_v is high, flush is low, and none of the
//   operand or destination registers is busy (RAW and WAW hazards both
//   stall). On an accepted issue, the operands are registered into
//   rs1_data/rs2_data and iss_v pulses for one cycle. A write-back writes
//   the register and clears its busy bit. Setting and clearing the same
//   busy bit in one cycle leaves it set. flush clears the whole scoreboard.
//
//   Optional feature (macro WB_BYPASS_EN):
//     A same-cycle write-back is treated as not busy for hazard checking,
//     and its data is forwarded into the operand registers.
//     When the macro is undefined, hazard checking uses only the
//     registered busy bits.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   result     in   write-back data
//   rd         in   write-back destination index
//   result_v   in   write-back valid
//   dec_v      in   issue request valid
//   dec_rs1    in   source register 1 index
//   dec_rs2    in   source register 2 index
//   dec_rd     in   destination index of issuing instruction
//   dec_rd_v   in   issuing instruction writes dec_rd
//   flush      in   clear scoreboard, block issue
//   dec_ready  out  issue accepted this cycle (combinational)
//   iss_v      out  operand data valid (registered, one-cycle pulse)
//   rs1_data   out  registered operand 1
//   rs2_data   out  registered operand 2
//   pend_cnt   out  number of busy registers
// ----------------------------------------------------------------------------
module reg_manager #(
    parameter int unsigned xlen = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [xlen-1:0] result,
    input  logic [4:0]      rd,
    input  logic            result_v,
    input  logic            dec_v,
    input  logic [4:0]      dec_rs1,
    input  logic [4:0]      dec_rs2,
    input  logic [4:0]      dec_rd,
    input  logic            dec_rd_v,
    input  logic            flush,
    output logic            dec_ready,
    output logic            iss_v,
    output logic [xlen-1:0] rs1_data,
    output logic [xlen-1:0] rs2_data,
    output logic [5:0]      pend_cnt
);

    logic [xlen-1:0] regs_q [32];
    logic [31:0]     busy_q;
    logic [31:0]     busy_d;
    logic            iss_v_q;
    logic [xlen-1:0] rs1_q;
    logic [xlen-1:0] rs2_q;
    logic [5:0]      pend_q;
    logic [5:0]      pend_d;

    logic            wb_live;
    logic            hit_rs1;
    logic            hit_rs2;
    logic            hit_rd;
    logic            hazard;
    logic            accept;
    logic [xlen-1:0] rs1_val;
    logic [xlen-1:0] rs2_val;

    // A write-back to x0 is ignored.
    assign wb_live = result_v && (rd != 5'd0);

`ifdef WB_BYPASS_EN
    assign hit_rs1 = wb_live && (rd == dec_rs1);
    assign hit_rs2 = wb_live && (rd == dec_rs2);
    assign hit_rd  = wb_live && (rd == dec_rd);
`else
    assign hit_rs1 = 1'b0;
    assign hit_rs2 = 1'b0;
    assign hit_rd  = 1'b0;
`endif

    // A busy bit whose write-back arrives this cycle counts as free
    // only when bypass is enabled (the hit_* terms are 0 otherwise).
    assign hazard = (busy_q[dec_rs1] && !hit_rs1) ||
                    (busy_q[dec_rs2] && !hit_rs2) ||
                    (dec_rd_v && busy_q[dec_rd] && !hit_rd);

    assign accept    = dec_v && !hazard && !flush;
    assign dec_ready = accept;

    assign rs1_val = hit_rs1 ? result : regs_q[dec_rs1];
    assign rs2_val = hit_rs2 ? result : regs_q[dec_rs2];

    // Clear first, then set, so a same-index set wins; flush overrides both.
    always_comb begin
        busy_d = busy_q;
        if (wb_live) begin
            busy_d[rd] = 1'b0;
        end
        if (accept && dec_rd_v && (dec_rd != 5'd0)) begin
            busy_d[dec_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    // pend_cnt is registered from busy_d, so it updates on the same edge
    // as the busy bits.
    always_comb begin
        pend_d = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            pend_d = pend_d + 6'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_live) begin
            regs_q[rd] <= result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            pend_q  <= '0;
            iss_v_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            iss_v_q <= accept;
            if (accept) begin
                rs1_q <= rs1_val;
                rs2_q <= rs2_val;
            end
        end
    end

    assign iss_v    = iss_v_q;
    assign rs1_data = rs1_q;
    assign rs2_data = rs2_q;
    assign pend_cnt = pend_q;

endmodule

// File: tb/tb_reg_manager.sv
module tb_reg_manager;

    logic        clk;
    logic        rst_n;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        result_v;
    logic        dec_v;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_rd_v;
    logic        flush;
    logic        dec_ready;
    logic        iss_v;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [5:0]  pend_cnt;

    int n_checks = 0;
    int n_errors = 0;

    reg_manager #(.xlen(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .result   (result),
        .rd       (rd),
        .result_v (result_v),
        .dec_v    (dec_v),
        .dec_rs1  (dec_rs1),
        .dec_rs2  (dec_rs2),
        .dec_rd   (dec_rd),
        .dec_rd_v (dec_rd_v),
        .flush    (flush),
        .dec_ready(dec_ready),
        .iss_v    (iss_v),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [4:0]  wrd;
        logic [31:0] res;
        logic        dv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  drd;
        logic        drdv;
        logic        fl;
        logic        e_ready;
        logic        e_iss;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [5:0]  e_pend;
    } vec_t;

    function automatic vec_t mk(
        input logic rv, input logic [4:0] wrd, input logic [31:0] res,
        input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] drd, input logic drdv, input logic fl,
        input logic e_ready, input logic e_iss,
        input logic [31:0] e_rs1, input logic [31:0] e_rs2, input logic [5:0] e_pend);
        vec_t v;
        v.rv = rv; v.wrd = wrd; v.res = res;
        v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.drd = drd; v.drdv = drdv; v.fl = fl;
        v.e_ready = e_ready; v.e_iss = e_iss;
        v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        result_v = 1'b0; rd = '0; result = '0;
        dec_v = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_rd_v = 1'b0;
        flush = 1'b0;
    endtask

    // Drive one cycle of inputs, check dec_ready before the edge and the
    // registered outputs just after it.
    task automatic step(input vec_t v, input string nm);
        result_v = v.rv; rd = v.wrd; result = v.res;
        dec_v = v.dv; dec_rs1 = v.rs1; dec_rs2 = v.rs2;
        dec_rd = v.drd; dec_rd_v = v.drdv; flush = v.fl;
        #1;
        chk({nm, ".dec_ready"}, 32'(dec_ready), 32'(v.e_ready));
        @(posedge clk);
        #1;
        chk({nm, ".iss_v"},    32'(iss_v),    32'(v.e_iss));
        chk({nm, ".rs1_data"}, rs1_data,      v.e_rs1);
        chk({nm, ".rs2_data"}, rs2_data,      v.e_rs2);
        chk({nm, ".pend_cnt"}, 32'(pend_cnt), 32'(v.e_pend));
    endtask

    vec_t tbl [15];

    initial begin
        //               rv wrd res           dv rs1 rs2 drd drdv fl  rdy iss rs1d          rs2d          pend
        tbl[0]  = mk(0, 0, 32'h0,         1, 1,  2,  5,  1,  0,  1,  1,  32'h0,        32'h0,        6'd1);
        tbl[1]  = mk(1, 1, 32'h11,        0, 0,  0,  0,  0,  0,  0,  0,  32'h0,        32'h0,        6'd1);
        tbl[2]  = mk(1, 2, 32'h22,        0, 0,  0,  0,  0,  0,  0,  0,  32'h0,        32'h0,        6'd1);
        tbl[3]  = mk(0, 0, 32'h0,         1, 1,  2,  0,  0,  0,  1,  1,  32'h11,       32'h22,       6'd1);
        tbl[4]  = mk(0, 0, 32'h0,         1, 5,  0,  0,  0,  0,  0,  0,  32'h11,       32'h22,       6'd1);
        tbl[5]  = mk(0, 0, 32'h0,         1, 3,  4,  5,  1,  0,  0,  0,  32'h11,       32'h22,       6'd1);
        tbl[6]  = mk(1, 0, 32'h1234,      1, 0,  0,  0,  0,  0,  1,  1,  32'h0,        32'h0,        6'd1);
        tbl[7]  = mk(0, 0, 32'h0,         1, 1,  1,  0,  1,  0,  1,  1,  32'h11,       32'h11,       6'd1);
        tbl[8]  = mk(1, 3, 32'h33,        0, 0,  0,  0,  0,  0,  0,  0,  32'h11,       32'h11,       6'd1);
        tbl[9]  = mk(0, 0, 32'h0,         1, 3,  0,  6,  1,  0,  1,  1,  32'h33,       32'h0,        6'd2);
        tbl[10] = mk(0, 0, 32'h0,         1, 0,  0,  7,  1,  0,  1,  1,  32'h0,        32'h0,        6'd3);
        tbl[11] = mk(1, 7, 32'h55,        1, 0,  0,  8,  1,  1,  0,  0,  32'h0,        32'h0,        6'd0);
        tbl[12] = mk(0, 0, 32'h0,         1, 7,  5,  8,  1,  0,  1,  1,  32'h55,       32'h0,        6'd1);
        tbl[13] = mk(1, 8, 32'h88,        0, 0,  0,  0,  0,  0,  0,  0,  32'h55,       32'h0,        6'd0);
        tbl[14] = mk(0, 0, 32'h0,         1, 8,  1,  0,  0,  0,  1,  1,  32'h88,       32'h11,       6'd0);

        // Reset state, checked while reset is held.
        rst_n = 1'b0;
        drive_idle();
        #1;
        chk("reset.iss_v",    32'(iss_v),    32'h0);
        chk("reset.rs1_data", rs1_data,      32'h0);
        chk("reset.rs2_data", rs2_data,      32'h0);
        chk("reset.pend_cnt", 32'(pend_cnt), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Write-back arrives while a reader stalls on the same register.
        step(mk(0, 0, 32'h0,        1, 0, 0, 5, 1, 0,  1, 1, 32'h0, 32'h0, 6'd1), "raw.issue");
        step(mk(0, 0, 32'h0,        1, 5, 0, 0, 0, 0,  0, 0, 32'h0, 32'h0, 6'd1), "raw.stall");
`ifdef WB_BYPASS_EN
        step(mk(1, 5, 32'hDEADBEEF, 1, 5, 0, 0, 0, 0,  1, 1, 32'hDEADBEEF, 32'h0, 6'd0), "raw.fwd");
`else
        step(mk(1, 5, 32'hDEADBEEF, 1, 5, 0, 0, 0, 0,  0, 0, 32'h0, 32'h0, 6'd0), "raw.wb");
        step(mk(0, 0, 32'h0,        1, 5, 0, 0, 0, 0,  1, 1, 32'hDEADBEEF, 32'h0, 6'd0), "raw.late");
`endif

        // Issue to rd=9 in the same cycle as its write-back.
        step(mk(0, 0, 32'h0,  1, 0, 0, 9, 1, 0,  1, 1, 32'h0, 32'h0, 6'd1), "waw.issue");
`ifdef WB_BYPASS_EN
        step(mk(1, 9, 32'h99, 1, 0, 0, 9, 1, 0,  1, 1, 32'h0, 32'h0, 6'd1), "waw.same");
        step(mk(0, 0, 32'h0,  1, 9, 1, 0, 0, 0,  0, 0, 32'h0, 32'h0, 6'd1), "waw.busy");
        step(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 1,  0, 0, 32'h0, 32'h0, 6'd0), "waw.flush");
`else
        step(mk(1, 9, 32'h99, 1, 0, 0, 9, 1, 0,  0, 0, 32'h0, 32'h0, 6'd0), "waw.same");
        step(mk(0, 0, 32'h0,  1, 9, 1, 0, 0, 0,  1, 1, 32'h99, 32'h11, 6'd0), "waw.free");
        step(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 1,  0, 0, 32'h99, 32'h11, 6'd0), "waw.flush");
`endif
        step(mk(0, 0, 32'h0,  1, 9, 1, 0, 0, 0,  1, 1, 32'h99, 32'h11, 6'd0), "waw.read9");

        // Mid-cycle asynchronous reset with four registers busy.
        step(mk(0, 0, 32'h0, 1, 1, 2, 10, 1, 0,  1, 1, 32'h11, 32'h22, 6'd1), "rst.b10");
        step(mk(0, 0, 32'h0, 1, 1, 2, 11, 1, 0,  1, 1, 32'h11, 32'h22, 6'd2), "rst.b11");
        step(mk(0, 0, 32'h0, 1, 1, 2, 12, 1, 0,  1, 1, 32'h11, 32'h22, 6'd3), "rst.b12");
        step(mk(0, 0, 32'h0, 1, 1, 2, 13, 1, 0,  1, 1, 32'h11, 32'h22, 6'd4), "rst.b13");
        result_v = 1'b1; rd = 5'd3; result = 32'hCAFE;
        dec_v = 1'b1; dec_rs1 = 5'd1; dec_rs2 = 5'd2; dec_rd = 5'd14; dec_rd_v = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async.iss_v",    32'(iss_v),    32'h0);
        chk("rst.async.rs1_data", rs1_data,      32'h0);
        chk("rst.async.rs2_data", rs2_data,      32'h0);
        chk("rst.async.pend_cnt", 32'(pend_cnt), 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        step(mk(0, 0, 32'h0, 1, 1, 3, 0, 0, 0,  1, 1, 32'h0, 32'h0, 6'd0), "rst.regs13");
        step(mk(0, 0, 32'h0, 1, 8, 10, 14, 1, 0, 1, 1, 32'h0, 32'h0, 6'd1), "rst.regs8");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
